// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - eight-way fixed-priority / round-robin arbiter with hold timeout
module req_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] last;
  logic [7:0] skip;

  logic [7:0] masked;
  logic [7:0] eligible;
  logic [2:0] win_fp;
  logic [2:0] win_rr;
  logic [2:0] rr_idx;
  logic       rr_found;
  logic [2:0] winner;
  logic       hold_release;
  logic       req_drop;

  // A skipped requester that is the only one asking is granted anyway.
  always_comb begin
    masked   = req & ~skip;
    eligible = (masked != 8'd0) ? masked : req;
  end

  always_comb begin
    win_fp = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) win_fp = 3'(i);
    end
  end

  // Scan last+1 .. last+8 (mod 8); the previous winner is checked last.
  always_comb begin
    win_rr   = 3'd0;
    rr_idx   = 3'd0;
    rr_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rr_idx = last + 3'(i);
      if (!rr_found && eligible[rr_idx]) begin
        win_rr   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    winner       = mode ? win_rr : win_fp;
    hold_release = HOLD_EN && (hold_cnt == HOLD_LAST);
    req_drop     = !req[gnt_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 8'd0;
      gnt_id   <= 3'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      last     <= 3'd7;
      skip     <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (eligible != 8'd0)) begin
            gnt      <= 8'd1 << winner;
            gnt_id   <= winner;
            busy     <= 1'b1;
            hold_cnt <= 8'd0;
            last     <= winner;
            skip     <= 8'd0;
            state    <= GRANT;
          end else begin
            skip <= 8'd0;
          end
        end
        GRANT: begin
          // Timeout wins over a simultaneous release so the skip is still recorded.
          if (hold_release) begin
            skip    <= gnt;
            timeout <= 1'b1;
            gnt     <= 8'd0;
            gnt_id  <= 3'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (req_drop) begin
            gnt    <= 8'd0;
            gnt_id <= 3'd0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - directed-vector bench for req_arbiter
module tb_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_bad;

  req_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_id);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_gnt != 8'd0));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    req   = 8'hFF;

    // reset and idle with en=0
    step(2);
    chk_grant("rst", 8'h00, 3'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk_grant("en0", 8'h00, 3'd0);

    // fixed priority
    en  = 1'b1;
    req = 8'b0010_0110;
    step(1);
    chk_grant("fp.first", 8'b0010_0000, 3'd5);
    req = 8'b0000_0110;
    step(1);
    chk_grant("fp.gap", 8'h00, 3'd0);
    step(1);
    chk_grant("fp.second", 8'b0000_0100, 3'd2);
    req = 8'h00;
    step(2);
    chk_grant("fp.done", 8'h00, 3'd0);

    // round-robin from a fresh reset (last = 7)
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] id;
      id = 3'(k);
      step(1);
      chk_grant($sformatf("rr.g%0d", k), 8'd1 << id, id);
      step(1);
      req = 8'hFF & ~(8'd1 << id);
      step(1);
      chk_grant($sformatf("rr.r%0d", k), 8'h00, 3'd0);
      req = 8'hFF;
    end
    req = 8'h00;
    step(2);

    // timeout, then the skipped requester loses to requester 0
    mode = 1'b0;
    req  = 8'b0000_1001;
    step(1);
    chk_grant("to.g", 8'b0000_1000, 3'd3);
    step(3);
    chk_grant("to.hold4", 8'b0000_1000, 3'd3);
    chk("to.nopulse", 32'(timeout), 32'd0);
    step(1);
    chk_grant("to.rel", 8'h00, 3'd0);
    chk("to.pulse", 32'(timeout), 32'd1);
    step(1);
    chk_grant("to.next", 8'b0000_0001, 3'd0);
    chk("to.pulse_end", 32'(timeout), 32'd0);
    req = 8'h00;
    step(2);

    // timeout with only the skipped requester asking
    req = 8'b0000_1000;
    step(4);
    chk_grant("tos.hold", 8'b0000_1000, 3'd3);
    step(1);
    chk("tos.pulse", 32'(timeout), 32'd1);
    chk_grant("tos.rel", 8'h00, 3'd0);
    step(1);
    chk_grant("tos.regrant", 8'b0000_1000, 3'd3);
    req = 8'h00;
    step(2);

    // en/mode changes during a grant
    req = 8'b0100_0000;
    step(1);
    chk_grant("em.g", 8'b0100_0000, 3'd6);
    en   = 1'b0;
    mode = 1'b1;
    req  = 8'hFF;
    step(2);
    chk_grant("em.held", 8'b0100_0000, 3'd6);
    req = 8'b1011_1111;
    step(1);
    chk_grant("em.rel", 8'h00, 3'd0);
    step(2);
    chk_grant("em.blocked", 8'h00, 3'd0);

    // asynchronous reset mid-grant
    en   = 1'b1;
    mode = 1'b0;
    req  = 8'b0001_0000;
    step(1);
    chk_grant("ar.g", 8'b0001_0000, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_grant("ar.clr", 8'h00, 3'd0);
    step(1);
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'h11;
    step(1);
    chk_grant("ar.rr", 8'b0000_0001, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
